// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: branch opcodes and default widths.
// No logic and no latency.
// No backpressure; these are constants only.
package branch_resolve_unit_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int IMM_W_DEF = 16;
  localparam int OP_W      = 6;

  localparam logic [OP_W-1:0] OP_BGT  = 6'b001000;
  localparam logic [OP_W-1:0] OP_BLT  = 6'b001001;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b001010;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b001011;
  localparam logic [OP_W-1:0] OP_BGTU = 6'b001100;
  localparam logic [OP_W-1:0] OP_BLTU = 6'b001101;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: decodes the opcode and compares a against b.
// Purely combinational, zero latency.
// No backpressure; the result follows the inputs.
module branch_cond
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [OP_W-1:0] opcode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            taken,
  output logic            is_branch
);

  // Compare the full-width operands directly so signed overflow cannot corrupt the result
  always_comb begin
    taken     = 1'b0;
    is_branch = 1'b1;
    case (opcode)
      OP_BGT:  taken = $signed(a) > $signed(b);
      OP_BLT:  taken = $signed(a) < $signed(b);
      OP_BEQ:  taken = (a == b);
      OP_BNE:  taken = (a != b);
      OP_BGTU: taken = (a > b);
      OP_BLTU: taken = (a < b);
      default: is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution: evaluates the condition, computes next PC, counts branches.
// One cycle from accept to out_valid; a single output register gives full throughput.
// in_ready drops only while a held result is not being drained by out_ready.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int IMM_W = IMM_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  opcode,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  rs_a,
  input  logic [XLEN-1:0]  rs_b,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  next_pc,
  output logic             taken,
  output logic             is_branch,
  output logic             flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] tk_count,
  input  logic             cnt_clr
);

  localparam int EXT_W = XLEN - IMM_W;

  logic            cond_taken;
  logic            cond_branch;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fall_thru;
  logic [XLEN-1:0] resolved_pc;
  logic            accept;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .opcode    (opcode),
    .a         (rs_a),
    .b         (rs_b),
    .taken     (cond_taken),
    .is_branch (cond_branch)
  );

  // Target and fall-through wrap modulo 2^XLEN; the handshake is a single output stage
  always_comb begin
    target      = pc_in + {{EXT_W{imm[IMM_W-1]}}, imm};
    fall_thru   = pc_in + {{(XLEN-1){1'b0}}, 1'b1};
    resolved_pc = cond_taken ? target : fall_thru;
    in_ready    = !out_valid || out_ready;
    accept      = in_valid && in_ready;
    flush       = out_valid && out_ready && taken;
  end

  // Output register: load on accept, drop valid on a drain with nothing new
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      next_pc   <= '0;
      taken     <= 1'b0;
      is_branch <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      next_pc   <= resolved_pc;
      taken     <= cond_taken;
      is_branch <= cond_branch;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count <= '0;
      tk_count <= '0;
    end else if (cnt_clr) begin
      br_count <= '0;
      tk_count <= '0;
    end else if (accept && cond_branch) begin
      if (br_count != {CNT_W{1'b1}}) br_count <= br_count + 1'b1;
      if (cond_taken && (tk_count != {CNT_W{1'b1}})) tk_count <= tk_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with 2-bit counters to reach saturation.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// Backpressure is exercised by holding out_ready low with a request waiting.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int XLEN  = 32;
  localparam int IMM_W = 16;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  opcode;
  logic [XLEN-1:0]  pc_in;
  logic [XLEN-1:0]  rs_a;
  logic [XLEN-1:0]  rs_b;
  logic [IMM_W-1:0] imm;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  next_pc;
  logic             taken;
  logic             is_branch;
  logic             flush;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] tk_count;
  logic             cnt_clr;

  int checks;
  int failures;

  branch_resolve_unit #(.XLEN(XLEN), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .pc_in     (pc_in),
    .rs_a      (rs_a),
    .rs_b      (rs_b),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .next_pc   (next_pc),
    .taken     (taken),
    .is_branch (is_branch),
    .flush     (flush),
    .br_count  (br_count),
    .tk_count  (tk_count),
    .cnt_clr   (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [OP_W-1:0] op, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [IMM_W-1:0] im);
    opcode = op;
    pc_in  = pc;
    rs_a   = a;
    rs_b   = b;
    imm    = im;
  endtask

  // Present one request with out_ready high; it is accepted on the next edge
  task automatic issue(input logic [OP_W-1:0] op, input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [IMM_W-1:0] im);
    set_req(op, pc, a, b, im);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    set_req(6'd0, '0, '0, '0, '0);

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_next_pc",   next_pc, 0);
    check("rst_taken",     taken, 0);
    check("rst_flush",     flush, 0);
    check("rst_br_count",  br_count, 0);
    check("rst_tk_count",  tk_count, 0);
    rst_n = 1'b1;
    #1;

    // BGT 5 > -3 signed, accepted on the first edge after reset
    set_req(OP_BGT, 32'h100, 32'd5, 32'hFFFF_FFFD, 16'h0002);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("bgt_out_valid", out_valid, 1);
    check("bgt_taken",     taken, 1);
    check("bgt_is_branch", is_branch, 1);
    check("bgt_next_pc",   next_pc, 32'h102);
    check("bgt_flush_held", flush, 0);
    check("bgt_in_ready_held", in_ready, 0);
    check("bgt_br_count",  br_count, 1);
    check("bgt_tk_count",  tk_count, 1);
    out_ready = 1'b1;
    #1;
    check("bgt_flush_pulse", flush, 1);
    check("bgt_in_ready_drain", in_ready, 1);
    step();
    check("bgt_drained_valid", out_valid, 0);
    check("bgt_flush_end", flush, 0);

    // BGTU: 5 > 0xFFFFFFFD unsigned is false
    issue(OP_BGTU, 32'h100, 32'd5, 32'hFFFF_FFFD, 16'h0002);
    check("bgtu_taken",   taken, 0);
    check("bgtu_next_pc", next_pc, 32'h101);
    check("bgtu_flush",   flush, 0);

    // BLT: most negative value < 1 with no overflow error
    issue(OP_BLT, 32'h200, 32'h8000_0000, 32'd1, 16'h0004);
    check("blt_taken",   taken, 1);
    check("blt_next_pc", next_pc, 32'h204);
    check("blt_br_count", br_count, 3);
    check("blt_tk_count", tk_count, 2);

    // Clear counters on an idle cycle
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_br_count", br_count, 0);
    check("clr_tk_count", tk_count, 0);

    // BEQ with a negative offset
    issue(OP_BEQ, 32'h10, 32'd0, 32'd0, 16'hFFFC);
    check("beq_taken",   taken, 1);
    check("beq_next_pc", next_pc, 32'h0C);

    // Non-branch at the top of the address space wraps, counters untouched
    issue(6'b000000, 32'hFFFF_FFFF, 32'd7, 32'd7, 16'h0010);
    check("nb_is_branch", is_branch, 0);
    check("nb_taken",     taken, 0);
    check("nb_next_pc",   next_pc, 32'h0);
    check("nb_br_count",  br_count, 1);
    check("nb_tk_count",  tk_count, 1);

    // Backpressure: held result, waiting request, three stalled cycles
    out_ready = 1'b0;
    set_req(OP_BNE, 32'h300, 32'd1, 32'd2, 16'h0008);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready",  in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_next_pc",   next_pc, 32'h0);
      check("bp_is_branch", is_branch, 0);
      check("bp_br_count",  br_count, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    step();
    check("stream0_next_pc", next_pc, 32'h308);
    check("stream0_taken",   taken, 1);
    set_req(OP_BEQ, 32'h400, 32'd9, 32'd9, 16'h0010);
    step();
    check("stream1_valid",   out_valid, 1);
    check("stream1_next_pc", next_pc, 32'h410);
    set_req(OP_BNE, 32'h500, 32'd4, 32'd4, 16'h0020);
    step();
    in_valid = 1'b0;
    check("stream2_next_pc", next_pc, 32'h501);
    check("stream2_taken",   taken, 0);
    check("stream_br_sat",   br_count, 3);
    check("stream_tk_sat",   tk_count, 3);

    // Saturation from zero with five taken branches, then clear beats increment
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(OP_BEQ, 32'h40 + i, 32'd3, 32'd3, 16'h0001);
    end
    check("sat_br_count", br_count, 3);
    check("sat_tk_count", tk_count, 3);
    cnt_clr = 1'b1;
    issue(OP_BEQ, 32'h80, 32'd3, 32'd3, 16'h0001);
    cnt_clr = 1'b0;
    check("clr_pri_br", br_count, 0);
    check("clr_pri_tk", tk_count, 0);
    check("clr_pri_next_pc", next_pc, 32'h81);

    // Asynchronous reset while a result is held under backpressure
    out_ready = 1'b0;
    issue(OP_BLTU, 32'h900, 32'd1, 32'd2, 16'h0004);
    out_ready = 1'b0;
    step();
    check("arst_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready",  in_ready, 1);
    check("arst_next_pc",   next_pc, 0);
    #1;
    rst_n = 1'b1;
    issue(OP_BNE, 32'h600, 32'd1, 32'd2, 16'h0003);
    check("post_rst_valid",   out_valid, 1);
    check("post_rst_taken",   taken, 1);
    check("post_rst_next_pc", next_pc, 32'h603);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
